// File: rtl/ok_wire_out_bank.sv
// Multi-channel Wire Out endpoint: atomic snapshot of NUM_CH user wires on host update,
// with user hold-off, hold timeout and sticky channels. Define WIRE_OUT_SEQ_EN for the status channel.
module ok_wire_out_bank #(
  parameter int                NUM_CH       = 4,
  parameter logic [7:0]        BASE_ADDR    = 8'h20,
  parameter logic [NUM_CH-1:0] STICKY_MASK  = '0,
  parameter int                HOLD_TIMEOUT = 255
) (
  input  logic                 ti_clk,
  input  logic                 ti_reset,
  input  logic                 ti_wireupdate,
  input  logic [7:0]           ti_addr,
  input  logic [NUM_CH*32-1:0] ep_datain,
  input  logic                 ep_hold,
  output logic                 ep_captured,
  output logic                 ep_timeout,
  output logic [31:0]          eh_data,
  output logic                 eh_ready,
  output logic [31:0]          eh_regreaddata
);

  localparam int             HCW       = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_TIMEOUT - 1);

  logic                     pending;
  logic [HCW-1:0]           hold_cnt;
  logic                     cap_req;
  logic                     capture;
  logic                     timeout_hit;
  logic                     forced;
  logic [NUM_CH-1:0][31:0]  snap;
  logic [NUM_CH-1:0][31:0]  acc;

  // Request/hold handshake: a request (ti_wireupdate, or one still pending) completes on the
  // first edge where ep_hold is low, or on the timeout edge; further requests meanwhile merge into it.
  always_comb begin
    cap_req     = ti_wireupdate | pending;
    timeout_hit = (HOLD_TIMEOUT != 0) && pending && (hold_cnt == HOLD_LAST);
    capture     = cap_req & (~ep_hold | timeout_hit);
    forced      = capture & timeout_hit & ep_hold;
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      pending     <= 1'b0;
      hold_cnt    <= '0;
      ep_captured <= 1'b0;
      ep_timeout  <= 1'b0;
    end else begin
      pending     <= cap_req & ~capture;
      hold_cnt    <= (pending && !capture) ? hold_cnt + 1'b1 : '0;
      ep_captured <= capture;
      if (forced) ep_timeout <= 1'b1;
    end
  end

  // Sticky channels fold the capture-cycle input straight into the snapshot so nothing is lost or doubled.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      snap <= '0;
      acc  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture) begin
          snap[i] <= STICKY_MASK[i] ? (acc[i] | ep_datain[32*i +: 32]) : ep_datain[32*i +: 32];
          acc[i]  <= '0;
        end else if (STICKY_MASK[i]) begin
          acc[i]  <= acc[i] | ep_datain[32*i +: 32];
        end
      end
    end
  end

`ifdef WIRE_OUT_SEQ_EN
  localparam logic [7:0] SEQ_ADDR = BASE_ADDR + 8'(NUM_CH);

  logic [15:0] cap_cnt;
  logic [7:0]  coal_cnt;
  logic [7:0]  coal_next;
  logic [24:0] seq_snap;

  always_comb begin
    coal_next = coal_cnt;
    if (pending && ti_wireupdate && coal_cnt != 8'hFF) coal_next = coal_cnt + 8'd1;
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      cap_cnt  <= '0;
      coal_cnt <= '0;
      seq_snap <= '0;
    end else if (capture) begin
      cap_cnt  <= cap_cnt + 16'd1;
      coal_cnt <= '0;
      seq_snap <= {forced, coal_next, cap_cnt + 16'd1};
    end else begin
      coal_cnt <= coal_next;
    end
  end
`endif

  // Out-of-range addresses read 0 so this bus can be OR-combined with the other endpoints.
  always_comb begin
    eh_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ti_addr == BASE_ADDR + 8'(i)) eh_data = snap[i];
    end
`ifdef WIRE_OUT_SEQ_EN
    if (ti_addr == SEQ_ADDR) eh_data = {7'd0, seq_snap};
`endif
  end

  assign eh_ready       = 1'b0;
  assign eh_regreaddata = '0;

endmodule
